// File: rtl/decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with three modes: static decode (hold),
// walking scan with wrap, and a timed pulse guarded by a busy flag.
module decoder_seq #(
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    load,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic                    y_valid,
    output logic                    err
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SCAN  = 2'd2,
        PULSE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_DECODE = 2'b00,
        M_SCAN   = 2'b01,
        M_PULSE  = 2'b10,
        M_RSVD   = 2'b11
    } mode_t;

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   idx_next;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // SEL_W-bit addition wraps OUT_W-1 back to 0 on its own.
    assign idx_next = idx + SEL_W'(1);

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would make later lines see updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else if (en) begin
            err <= 1'b0;
            if (clr) begin
                state   <= IDLE;
                cnt     <= '0;
                y       <= '0;
                y_valid <= 1'b0;
                busy    <= 1'b0;
            end else if (load && !busy) begin
                unique case (mode_t'(mode))
                    M_DECODE: begin
                        idx     <= sel;
                        y       <= onehot(sel);
                        y_valid <= 1'b1;
                        state   <= HOLD;
                    end
                    M_SCAN: begin
                        idx     <= sel;
                        y       <= onehot(sel);
                        y_valid <= 1'b1;
                        state   <= SCAN;
                    end
                    M_PULSE: begin
                        idx     <= sel;
                        y       <= onehot(sel);
                        y_valid <= 1'b1;
                        cnt     <= CNT_W'(PULSE_LEN - 1);
                        busy    <= 1'b1;
                        state   <= PULSE;
                    end
                    M_RSVD: err <= 1'b1;
                endcase
            end else begin
                unique case (state)
                    IDLE, HOLD: ;
                    SCAN: begin
                        idx <= idx_next;
                        y   <= onehot(idx_next);
                    end
                    PULSE: begin
                        // The cycle that sees cnt==0 is the last y-high cycle.
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            y       <= '0;
                            y_valid <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed vector table plus hand-written multi-cycle sequences for decoder_seq,
// and a randomised SEL_W=4 stream checked against an independent reference model.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, load;
    logic [1:0] mode, sel;
    logic       busy, y_valid, err;
    logic [3:0] y;

    logic        en4, clr4, load4;
    logic [1:0]  mode4;
    logic [3:0]  sel4;
    logic        busy4, y_valid4, err4;
    logic [15:0] y4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_seq #(.SEL_W(2), .PULSE_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .mode(mode),
        .sel(sel), .busy(busy), .y(y), .y_valid(y_valid), .err(err)
    );

    decoder_seq #(.SEL_W(4), .PULSE_LEN(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr4), .load(load4), .mode(mode4),
        .sel(sel4), .busy(busy4), .y(y4), .y_valid(y_valid4), .err(err4)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic       load;
        logic [1:0] mode;
        logic [1:0] sel;
        logic [3:0] exp_y;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic l,
                         input logic [1:0] m, input logic [1:0] s);
        en = e; clr = c; load = l; mode = m; sel = s;
    endtask

    task automatic check_outs(input string name, input logic [3:0] ey,
                              input logic eb, input logic ee);
        check({name, ".y"}, 32'(y), 32'(ey));
        check({name, ".y_valid"}, 32'(y_valid), 32'(ey != 4'b0));
        check({name, ".busy"}, 32'(busy), 32'(eb));
        check({name, ".err"}, 32'(err), 32'(ee));
    endtask

    // Reference model state for the SEL_W=4, PULSE_LEN=3 instance.
    int          m_st;     // 0 idle, 1 hold, 2 scan, 3 pulse
    logic [3:0]  m_idx;
    logic [15:0] m_y;
    logic        m_busy, m_err;
    int          m_done;   // y-high cycles already produced in the current pulse

    initial begin
        // en clr load mode sel   y  busy err
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 4'b0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'b00, 2'd1, 4'b0010, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'b00, 2'd2, 4'b0100, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b00, 2'd3, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b1000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b01, 2'd1, 4'b1000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'b01, 2'd2, 4'b0100, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b1000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b0001, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b0010, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b0100, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 4'b0100, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 4'b0100, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 4'b0100, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b1000, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 2'b00, 2'd3, 4'b1000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 2'b00, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 2'b00, 2'd3, 4'b1000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 2'b11, 2'd0, 4'b1000, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 4'b1000, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
        en4 = 1'b0; clr4 = 1'b0; load4 = 1'b0; mode4 = 2'b00; sel4 = 4'd0;
        #12;
        check_outs("reset", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("post_reset_idle", 4'b0000, 1'b0, 1'b0);

        // Decode sweep, scan wrap, en freeze, clr-over-load priority, reserved mode.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].mode, vecs[i].sel);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_busy, vecs[i].exp_err);
        end

        // PULSE: exactly 4 high cycles with busy, load at pulse cycle 2 dropped.
        drive(1'b1, 1'b0, 1'b1, 2'b10, 2'd1);
        tick();
        check_outs("pulse_c1", 4'b0010, 1'b1, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            if (k == 2) drive(1'b1, 1'b0, 1'b1, 2'b00, 2'd3);
            else        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
            tick();
            check_outs($sformatf("pulse_c%0d", k), 4'b0010, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        tick();
        check_outs("pulse_end", 4'b0000, 1'b0, 1'b0);
        tick();
        check_outs("pulse_idle", 4'b0000, 1'b0, 1'b0);

        // clr aborts a pulse in progress.
        drive(1'b1, 1'b0, 1'b1, 2'b10, 2'd2);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        tick();
        check_outs("pulse2_c2", 4'b0100, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 2'd0);
        tick();
        check_outs("pulse2_clr", 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);

        // Asynchronous reset mid-SCAN takes effect before the next edge.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 2'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        tick();
        check_outs("scan_pre_rst", 4'b0010, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("scan_async_rst", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_outs("scan_after_rst", 4'b0000, 1'b0, 1'b0);

        // Reset mid-PULSE: no pulse resumes after release.
        drive(1'b1, 1'b0, 1'b1, 2'b10, 2'd3);
        tick();
        check_outs("pulse3_c1", 4'b1000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
        #1 rst_n = 1'b0;
        #1;
        check_outs("pulse3_rst", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check_outs("pulse3_no_resume", 4'b0000, 1'b0, 1'b0);

        // SEL_W=4 random stream against the reference model.
        drive(1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
        m_st = 0; m_idx = '0; m_y = '0; m_busy = 1'b0; m_err = 1'b0; m_done = 0;
        for (int c = 0; c < 300; c++) begin
            en4   = ($urandom_range(0, 9) != 0);
            clr4  = ($urandom_range(0, 19) == 0);
            load4 = ($urandom_range(0, 9) < 4);
            mode4 = 2'($urandom_range(0, 3));
            sel4  = 4'($urandom_range(0, 15));
            if (en4) begin
                m_err = 1'b0;
                if (clr4) begin
                    m_st = 0; m_y = '0; m_busy = 1'b0;
                end else if (load4 && !m_busy) begin
                    if (mode4 == 2'b11) begin
                        m_err = 1'b1;
                    end else begin
                        m_idx = sel4;
                        m_y   = 16'(1) << sel4;
                        if (mode4 == 2'b00) m_st = 1;
                        else if (mode4 == 2'b01) m_st = 2;
                        else begin
                            m_st = 3; m_busy = 1'b1; m_done = 1;
                        end
                    end
                end else if (m_st == 2) begin
                    m_idx = m_idx + 4'd1;
                    m_y   = 16'(1) << m_idx;
                end else if (m_st == 3) begin
                    if (m_done == 3) begin
                        m_st = 0; m_y = '0; m_busy = 1'b0;
                    end else begin
                        m_done++;
                    end
                end
            end
            tick();
            check($sformatf("rnd%0d.y", c), 32'(y4), 32'(m_y));
            check($sformatf("rnd%0d.y_valid", c), 32'(y_valid4), 32'(m_y != '0));
            check($sformatf("rnd%0d.onehot", c), 32'($countones(y4) <= 1), 32'd1);
            check($sformatf("rnd%0d.busy", c), 32'(busy4), 32'(m_busy));
            check($sformatf("rnd%0d.err", c), 32'(err4), 32'(m_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
